// File: rtl/p405s_strgldgather_pkg.sv
// Shared types and helpers for the string/multiple load gather stage.
// Holds the FSM encoding, stage geometry and the byte-lane merge used by the packer.
package p405s_strgPkg;

    localparam int unsigned STRG_MAX_BYTES = 128;
    localparam int unsigned STAGE_BYTES    = 7;
    localparam int unsigned STAGE_W        = 8 * STAGE_BYTES;
    localparam int unsigned WORD_W         = 32;
    localparam int unsigned GPR_AW         = 5;
    localparam int unsigned REMAIN_W       = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GATHER = 2'd1,
        ST_DRAIN  = 2'd2
    } strgState_e;

    typedef struct packed {
        logic              en;
        logic [GPR_AW-1:0] addr;
        logic [WORD_W-1:0] data;
    } strgGprWr_t;

    // Keep the first stageCnt staged bytes and append eff bytes of beat (left-justified) behind them.
    function automatic logic [STAGE_W-1:0] strgMergeBytes(
        input logic [STAGE_W-1:0] stage,
        input logic [2:0]         stageCnt,
        input logic [WORD_W-1:0]  beat,
        input logic [2:0]         eff
    );
        logic [STAGE_W-1:0] keepMask;
        logic [WORD_W-1:0]  beatMask;
        logic [STAGE_W-1:0] beatWide;
        keepMask = ~({STAGE_W{1'b1}} >> {stageCnt, 3'b000});
        beatMask = ~({WORD_W{1'b1}} >> {eff, 3'b000});
        beatWide = {beat & beatMask, {(STAGE_W - WORD_W){1'b0}}} >> {stageCnt, 3'b000};
        return (stage & keepMask) | beatWide;
    endfunction

endpackage

// File: rtl/p405s_strgldgather_bytemerge.sv
// Combinational byte-lane shifter: drops eff beat bytes at offset stageCnt in the 7-byte stage.
module p405s_strgByteMerge
    import p405s_strgPkg::*;
(
    input  logic [STAGE_W-1:0] stage,
    input  logic [2:0]         stageCnt,
    input  logic [WORD_W-1:0]  beat,
    input  logic [2:0]         eff,
    output logic [STAGE_W-1:0] mergedStage_c
);

    assign mergedStage_c = strgMergeBytes(stage, stageCnt, beat, eff);

endmodule

// File: rtl/p405s_strgldgather.sv
// Load-data gather for lswi/lswx/lmw: packs 1-4 byte beats big-endian into GPR words,
// stepping the target register mod 32 and zero-padding the final partial word.
module p405s_strgldgather
    import p405s_strgPkg::*;
(
    input  logic                CB,
    input  logic                RSTN,
    input  logic                gthStart,
    input  logic [GPR_AW-1:0]   gthRt,
    input  logic [6:0]          gthTotal,
    input  logic                gthRaSkipEn,
    input  logic [GPR_AW-1:0]   gthRa,
    input  logic                ldValid,
    input  logic [2:0]          ldBytes,
    input  logic [WORD_W-1:0]   ldData,
    input  logic                flush,
    output logic                ldReady,
    output logic                gprWrEn,
    output logic [GPR_AW-1:0]   gprWrAddr,
    output logic [WORD_W-1:0]   gprWrData,
    output logic                busy,
    output logic                done
);

    strgState_e          state, stateNext;
    logic [REMAIN_W-1:0] remain, remainNext;
    logic [STAGE_W-1:0]  stage, stageNext;
    logic [2:0]          stageCnt, stageCntNext;
    logic [GPR_AW-1:0]   rt, rtNext;
    logic [GPR_AW-1:0]   raQ, raNext;
    logic                skipEnQ, skipEnNext;
    strgGprWr_t          wrQ, wrNext;
    logic                doneQ, doneNext;
    logic                busyQ, busyNext;
    logic                ldReadyQ, ldReadyNext;

    logic [2:0]          legalBytes;
    logic [2:0]          eff;
    logic [2:0]          mergedCnt;
    logic [STAGE_W-1:0]  mergedStage_c;
    logic                accept;
    logic                skipHit;

    // Illegal sizes behave as a full word; the final beat is clipped to what is still owed.
    assign legalBytes = (ldBytes == 3'd0 || ldBytes > 3'd4) ? 3'd4 : ldBytes;
    assign eff        = (remain < {5'd0, legalBytes}) ? remain[2:0] : legalBytes;
    assign mergedCnt  = stageCnt + eff;
    assign accept     = ldValid & ldReadyQ;
    assign skipHit    = skipEnQ & (rt == raQ);

    p405s_strgByteMerge uMerge (
        .stage         (stage),
        .stageCnt      (stageCnt),
        .beat          (ldData),
        .eff           (eff),
        .mergedStage_c (mergedStage_c)
    );

    // State and datapath registers.
    always_ff @(posedge CB or negedge RSTN) begin
        if (!RSTN) begin
            state    <= ST_IDLE;
            remain   <= '0;
            stage    <= '0;
            stageCnt <= '0;
            rt       <= '0;
            raQ      <= '0;
            skipEnQ  <= 1'b0;
            wrQ      <= '0;
            doneQ    <= 1'b0;
            busyQ    <= 1'b0;
            ldReadyQ <= 1'b0;
        end else begin
            state    <= stateNext;
            remain   <= remainNext;
            stage    <= stageNext;
            stageCnt <= stageCntNext;
            rt       <= rtNext;
            raQ      <= raNext;
            skipEnQ  <= skipEnNext;
            wrQ      <= wrNext;
            doneQ    <= doneNext;
            busyQ    <= busyNext;
            ldReadyQ <= ldReadyNext;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        stateNext    = state;
        remainNext   = remain;
        stageNext    = stage;
        stageCntNext = stageCnt;
        rtNext       = rt;
        raNext       = raQ;
        skipEnNext   = skipEnQ;
        wrNext       = wrQ;
        wrNext.en    = 1'b0;
        doneNext     = 1'b0;

        case (state)
            ST_IDLE: begin
                if (gthStart) begin
                    stateNext    = ST_GATHER;
                    remainNext   = (gthTotal == 7'd0) ? REMAIN_W'(STRG_MAX_BYTES)
                                                      : {1'b0, gthTotal};
                    stageNext    = '0;
                    stageCntNext = '0;
                    rtNext       = gthRt;
                    raNext       = gthRa;
                    skipEnNext   = gthRaSkipEn;
                end
            end
            ST_GATHER: begin
                if (accept) begin
                    remainNext = remain - REMAIN_W'(eff);
                    if (mergedCnt >= 3'd4) begin
                        wrNext.en    = ~skipHit;
                        wrNext.addr  = rt;
                        wrNext.data  = mergedStage_c[STAGE_W-1 -: WORD_W];
                        stageNext    = mergedStage_c << WORD_W;
                        stageCntNext = mergedCnt - 3'd4;
                        rtNext       = rt + 5'd1;
                    end else begin
                        stageNext    = mergedStage_c;
                        stageCntNext = mergedCnt;
                    end
                    if (remainNext == '0) begin
                        if (stageCntNext != 3'd0) begin
                            stateNext = ST_DRAIN;
                        end else begin
                            stateNext = ST_IDLE;
                            doneNext  = 1'b1;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                // Bytes past stageCnt are always zero, so the top word is already padded.
                wrNext.en    = ~skipHit;
                wrNext.addr  = rt;
                wrNext.data  = stage[STAGE_W-1 -: WORD_W];
                stageNext    = '0;
                stageCntNext = '0;
                rtNext       = rt + 5'd1;
                stateNext    = ST_IDLE;
                doneNext     = 1'b1;
            end
            default: begin
                stateNext = ST_IDLE;
            end
        endcase

        // Flush aborts everything, including a start arriving in the same cycle.
        if (flush) begin
            stateNext    = ST_IDLE;
            remainNext   = '0;
            stageNext    = '0;
            stageCntNext = '0;
            rtNext       = rt;
            raNext       = raQ;
            skipEnNext   = skipEnQ;
            wrNext.en    = 1'b0;
            doneNext     = 1'b0;
        end

        busyNext    = (stateNext != ST_IDLE);
        ldReadyNext = (stateNext == ST_GATHER) && (remainNext != '0);
    end

    assign ldReady   = ldReadyQ;
    assign gprWrEn   = wrQ.en;
    assign gprWrAddr = wrQ.addr;
    assign gprWrData = wrQ.data;
    assign busy      = busyQ;
    assign done      = doneQ;

endmodule
